// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared ADC constants and averager state type
package adc_pkg;

  localparam int ADC_BITS = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CONV  = 2'd2,
    DRAIN = 2'd3
  } avg_state_t;

  // Channel addresses as understood by the serial ADC controller
  localparam logic [2:0] ADC_CH_VIN0 = 3'd0;
  localparam logic [2:0] ADC_CH_VIN1 = 3'd1;
  localparam logic [2:0] ADC_CH_VIN2 = 3'd2;
  localparam logic [2:0] ADC_CH_VIN3 = 3'd3;

endpackage

// File: rtl/adc_sample_averager_if.sv
// rtl/adc_sample_averager_if.sv - valid/ready result stream from the averager
interface adc_sample_averager_if;
  import adc_pkg::*;

  logic [ADC_BITS-1:0] avg_data;
  logic                avg_valid;
  logic                avg_ready;

  modport master (output avg_data, output avg_valid, input avg_ready);
  modport slave  (input avg_data, input avg_valid, output avg_ready);

endinterface

// File: rtl/adc_shift_in.sv
// rtl/adc_shift_in.sv - serial-in register capturing ADC DOUT MSB first
module adc_shift_in
  import adc_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sclk,
  input  logic                shift_en,
  input  logic                din,
  output logic [ADC_BITS-1:0] data
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= '0;
    end else if (shift_en && sclk) begin
      data <= {data[ADC_BITS-2:0], din};
    end
  end

endmodule

// File: rtl/adc_sample_averager.sv
// rtl/adc_sample_averager.sv - paces ADC conversions and averages 2^LOG2_AVG samples
module adc_sample_averager
  import adc_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = 64,
  parameter int unsigned LOG2_AVG      = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         adc_sclk,
  input  logic                         adc_shift_en,
  input  logic                         adc_dout,
  input  logic                         adc_data_ready,
  output logic                         get_adc_data,
  adc_sample_averager_if.master        avg,
  output logic                         overrun,
  output logic                         tick_missed
);

  localparam int ACC_W = ADC_BITS + LOG2_AVG;
  localparam int CNT_W = LOG2_AVG + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_AVG) - 1);

  avg_state_t          state, state_next;
  logic [15:0]         timer;
  logic                tick;
  logic                capture;
  logic [ADC_BITS-1:0] sample;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    sum;
  logic [CNT_W-1:0]    count;
  logic                last;
  logic                new_result;

  adc_shift_in u_shift_in (
    .clk      (clk),
    .reset_n  (reset_n),
    .sclk     (adc_sclk),
    .shift_en (adc_shift_en),
    .din      (adc_dout),
    .data     (sample)
  );

  assign tick = enable && (timer == 16'(SAMPLE_PERIOD - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (!enable || tick) begin
      timer <= '0;
    end else begin
      timer <= timer + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // A started conversion is always seen through; DRAIN swallows its result
  always_comb begin
    state_next   = state;
    get_adc_data = 1'b0;
    capture      = 1'b0;
    case (state)
      IDLE:  if (enable) state_next = WAIT;
      WAIT: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (tick) begin
          get_adc_data = 1'b1;
          state_next   = CONV;
        end
      end
      CONV: begin
        if (adc_data_ready) begin
          capture    = enable;
          state_next = enable ? WAIT : IDLE;
        end else if (!enable) begin
          state_next = DRAIN;
        end
      end
      DRAIN: if (adc_data_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign sum        = acc + ACC_W'(sample);
  assign last       = (count == LAST_CNT);
  assign new_result = capture && last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc   <= '0;
      count <= '0;
    end else if (!enable || new_result) begin
      acc   <= '0;
      count <= '0;
    end else if (capture) begin
      acc   <= sum;
      count <= count + CNT_W'(1);
    end
  end

  // A fresh result always wins over a same-cycle transfer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avg.avg_data  <= '0;
      avg.avg_valid <= 1'b0;
    end else if (new_result) begin
      avg.avg_data  <= sum[ACC_W-1:LOG2_AVG];
      avg.avg_valid <= 1'b1;
    end else if (avg.avg_valid && avg.avg_ready) begin
      avg.avg_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun     <= 1'b0;
      tick_missed <= 1'b0;
    end else if (!enable) begin
      overrun     <= 1'b0;
      tick_missed <= 1'b0;
    end else begin
      if (new_result && avg.avg_valid && !avg.avg_ready) overrun <= 1'b1;
      if (state == CONV && tick) tick_missed <= 1'b1;
    end
  end

endmodule

// File: doc/adc_sample_averager.md
Name: adc_sample_averager

Overview:
Downstream consumer of the serial ADC controller.
- Paces conversions by issuing one-clk get_adc_data requests at a fixed period.
- Deserialises the ADC DOUT line using the controller's sclk and shift_reg_enable.
- Captures each 12-bit sample on adc_data_ready, averages 2^LOG2_AVG samples, and presents the result on a valid/ready output towards display/UART logic.

Parameters:
SAMPLE_PERIOD, 64, clk cycles between conversion requests; legal range 40..65535 (one conversion takes ~34 clk).
LOG2_AVG, 2, log2 of samples per average; legal range 0..6.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  run control; low = stop sampling, clear accumulation
adc_sclk  in  1  serial clock from ADC controller
adc_shift_en  in  1  shift_reg_enable from ADC controller
adc_dout  in  1  ADC serial data, MSB first
adc_data_ready  in  1  one-clk pulse from controller: conversion complete
get_adc_data  out  1  one-clk conversion request to controller
avg_data  out  12  averaged sample
avg_valid  out  1  avg_data holds an unconsumed result
avg_ready  in  1  consumer accepts avg_data when avg_valid & avg_ready
overrun  out  1  sticky: an unconsumed result was overwritten
tick_missed  out  1  sticky: period tick arrived while a conversion was in flight

Behaviour:
- Reset: all outputs 0, shift register 0, accumulator 0, sample count 0, timer 0, FSM IDLE.
- Shift register (12 bit): on a clk posedge with adc_shift_en=1 and adc_sclk=1, shift {sr[10:0], adc_dout}. Shifting is independent of FSM state. After 12 shifts the register holds the sample MSB-first.
- Period timer:
  - Counts 0..SAMPLE_PERIOD-1 and wraps while enable=1.
  - Held at 0 while enable=0.
  - Terminal count (SAMPLE_PERIOD-1) is the "tick"; the first tick occurs SAMPLE_PERIOD clk after enable rises.
- FSM states IDLE, WAIT, CONV, DRAIN:
  - IDLE: enable=1 -> WAIT.
  - WAIT:
    - tick -> assert get_adc_data for exactly that one clk, go to CONV.
    - enable=0 -> IDLE.
  - CONV:
    - adc_data_ready=1 -> capture shift register as sample, go to WAIT; if enable=0 that cycle, go to IDLE and discard the sample.
    - enable=0 without adc_data_ready -> DRAIN.
    - A tick in CONV sets tick_missed; no request is issued.
  - DRAIN: wait for adc_data_ready, discard the sample, go to IDLE. Never abandon a conversion the controller has already started.
  - adc_data_ready in IDLE or WAIT: ignored.
- Accumulation:
  - Accumulator width 12+LOG2_AVG (unsigned, never overflows); sample count width LOG2_AVG+1.
  - On a captured sample, acc += sample and count += 1.
  - When count reaches 2^LOG2_AVG:
    - Result = (acc + sample) >> LOG2_AVG, truncated with no rounding, loaded into avg_data.
    - Acc and count are cleared in the same cycle.
  - avg_valid rises the clk after the final sample's adc_data_ready (1-clk latency).
  - LOG2_AVG=0: each sample passes straight through.
- Output handshake:
  - avg_valid stays high and avg_data is held stable until avg_valid & avg_ready.
  - Transfer without a new result: avg_valid -> 0 next clk.
  - New result while avg_valid=1 & avg_ready=0: overwrite avg_data, keep avg_valid=1, set overrun.
  - New result and transfer in the same clk: load the new data, avg_valid stays 1, no overrun.
- enable=0:
  - Accumulator, count and timer are cleared; overrun and tick_missed are cleared.
  - avg_data and avg_valid are retained until consumed.
- Asynchronous reset mid-conversion: immediate return to reset values. The controller is reset by the same reset_n.

Decomposition:
- Package adc_pkg:
  - ADC_BITS=12.
  - averager state enum {IDLE, WAIT, CONV, DRAIN} (2-bit logic).
  - Channel address constants shared with the controller.
- Sub-module adc_shift_in: 12-bit serial-in register with ports clk, reset_n, sclk, shift_en, din, data[11:0].
- Timer, FSM, accumulator and output register remain in the top level.

Test Plan:
- Setup for all scenarios: SAMPLE_PERIOD=50, LOG2_AVG=2, driven by a behavioural model of the controller plus ADC.
- enable=1, ADC returns 0x100, 0x200, 0x300, 0x400, avg_ready=1 -> exactly one get_adc_data pulse every 50 clk; avg_data=0x280; avg_valid high for 1 clk, starting 1 clk after the 4th adc_data_ready.
- Four samples of 0xFFF -> avg_data=0xFFF (no accumulator overflow). Samples 1, 1, 1, 2 -> avg_data=0x001 (truncation).
- avg_ready=0 across two full averages (0x010 x4, then 0x020 x4) -> avg_data=0x020, avg_valid=1, overrun=1. Drop enable -> overrun=0, avg_valid still 1.
- avg_ready pulses high in the exact clk the second result loads -> avg_data updates, avg_valid stays 1, overrun=0.
- enable falls 5 clk after a get_adc_data -> no further requests; the in-flight sample is discarded. Re-enable and sample 0x300 x4 -> avg_data=0x300, with no contamination from the discarded sample.
- Bench model holds adc_data_ready off for 60 clk -> tick_missed=1 and no extra get_adc_data pulse. Assert reset_n=0 mid-CONV -> all outputs 0 immediately.
